// File: rtl/arbitro_sumador.sv
// Round-robin arbiter that shares one external 8-bit adder between two requesters.
// Each grant runs ISSUE (one enable pulse), ADD_LAT wait cycles, then a one-cycle DONE.
module arbitro_sumador #(
    parameter int unsigned ADD_LAT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    input  logic [1:0] MODO0,
    input  logic [1:0] MODO1,
    input  logic       RCI0,
    input  logic       RCI1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] Q_OUT,
    output logic       RCO_OUT,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [1:0] MODO,
    output logic       ENB,
    output logic       RCI,
    input  logic [7:0] Q,
    input  logic       RCO
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Wait counter is loaded with ADD_LAT-1 so the capture happens on its zero cycle.
    localparam logic [3:0] WaitLoad = 4'(ADD_LAT - 1);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [1:0] modo_q, modo_d;
    logic       rci_q, rci_d;
    logic [7:0] q_out_q, q_out_d;
    logic       rco_out_q, rco_out_d;
    logic       winner;
    logic       busy;

    // With both requests high the pointer decides; otherwise the lone requester wins.
    assign winner = (REQ0 && REQ1) ? ptr_q : REQ1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        wait_cnt_d = wait_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        modo_d     = modo_q;
        rci_d      = rci_q;
        q_out_d    = q_out_q;
        rco_out_d  = rco_out_q;
        case (state_q)
            StIdle: begin
                if (REQ0 || REQ1) begin
                    owner_d = winner;
                    a_d     = winner ? A1 : A0;
                    b_d     = winner ? B1 : B0;
                    modo_d  = winner ? MODO1 : MODO0;
                    rci_d   = winner ? RCI1 : RCI0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = WaitLoad;
                state_d    = StWait;
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    q_out_d   = Q;
                    rco_out_d = RCO;
                    state_d   = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StDone: begin
                ptr_d   = ~owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            wait_cnt_q <= 4'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            modo_q     <= 2'd0;
            rci_q      <= 1'b0;
            q_out_q    <= 8'd0;
            rco_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wait_cnt_q <= wait_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            modo_q     <= modo_d;
            rci_q      <= rci_d;
            q_out_q    <= q_out_d;
            rco_out_q  <= rco_out_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign GNT0    = busy && !owner_q;
    assign GNT1    = busy && owner_q;
    assign DONE0   = (state_q == StDone) && !owner_q;
    assign DONE1   = (state_q == StDone) && owner_q;
    assign ENB     = (state_q == StIssue);
    assign A       = busy ? a_q : 8'd0;
    assign B       = busy ? b_q : 8'd0;
    assign MODO    = busy ? modo_q : 2'd0;
    assign RCI     = busy && rci_q;
    assign Q_OUT   = q_out_q;
    assign RCO_OUT = rco_out_q;

endmodule

// File: doc/arbitro_sumador.md
ARBITRO_SUMADOR -- requirements
Module: arbitro_sumador

Interface
REQ-001 SHALL have parameter ADD_LAT, default 1, meaning adder result latency in cycles after the ENB cycle (legal 1..15).
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  single clock, all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ0 / REQ1  in  1  operation request from requester 0 / 1
- A0, B0 / A1, B1  in  8  operands per requester
- MODO0 / MODO1  in  2  adder mode per requester
- RCI0 / RCI1  in  1  carry-in per requester
- GNT0 / GNT1  out  1  requester owns the adder
- DONE0 / DONE1  out  1  one-cycle result-valid pulse
- Q_OUT  out  8  captured result
- RCO_OUT  out  1  captured carry-out
- A, B  out  8  operands to the shared Sumador8Bits
- MODO  out  2  mode to the adder
- ENB  out  1  adder enable
- RCI  out  1  carry-in to the adder
- Q  in  8  adder result
- RCO  in  1  adder carry-out
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL share one adder between two requesters via an FSM: IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE: on an edge with REQ0 or REQ1 high, SHALL pick the winner, latch its A/B/MODO/RCI, set its GNT and go to ISSUE; else stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: pointer names the priority requester; after a transaction completes, the pointer moves to the other requester.
REQ-007 With exactly one REQ high, that requester SHALL win regardless of the pointer.
REQ-008 ISSUE SHALL last exactly 1 cycle: ENB=1 with A, B, MODO and RCI driven from the latched values; next state is WAIT.
REQ-009 WAIT SHALL last exactly ADD_LAT cycles with ENB=0 and the adder inputs held. On the last WAIT edge, Q and RCO SHALL be captured into Q_OUT and RCO_OUT; next state is DONE.
REQ-010 DONE SHALL last 1 cycle with DONEx=1 for the granted requester only; next state is IDLE.
REQ-011 GNTx SHALL be high from ISSUE through DONE inclusive and low in IDLE; GNT0 and GNT1 are never high together.
REQ-012 Latency: DONEx SHALL be high in the (ADD_LAT+2)th cycle after the edge that sampled REQx.
REQ-013 Operands SHALL be latched only in IDLE; requester input changes during a transaction have no effect.
REQ-014 If REQx drops mid-transaction, the transaction SHALL still complete and DONEx SHALL still pulse.
REQ-015 If REQx is still high in IDLE after its DONE, it SHALL count as a new request, subject to round-robin.
REQ-016 In IDLE, A, B, MODO and RCI SHALL be 0 and ENB=0.
REQ-017 Q_OUT and RCO_OUT SHALL hold their last captured value until the next capture.
REQ-018 Q_OUT and RCO_OUT SHALL be passed through without modification; MODO semantics are owned by the adder.

Reset
REQ-019 While RESET is high at an edge, the block SHALL go to IDLE, set the pointer to requester 0, and clear GNT0/1, DONE0/1, ENB, A, B, MODO, RCI, Q_OUT and RCO_OUT to 0.
REQ-020 RESET during ISSUE, WAIT or DONE SHALL abort the transaction: no DONE pulse, no capture; the requester must re-request.
REQ-021 RESET SHALL take priority over any REQ sampled at the same edge.

Verification
Bench uses an adder stub, ADD_LAT=1: on an edge with ENB=1 it registers Q=A+B+RCI and RCO=carry.
REQ-022 Single request: REQ0=1, A0=8'h12, B0=8'h34, RCI0=0 -> ISSUE cycle shows A=8'h12, B=8'h34, ENB=1; DONE0 pulses 3 cycles after the sample edge; Q_OUT=8'h46, RCO_OUT=0; GNT1 stays 0.
REQ-023 Carry: REQ1 with A1=8'hFF, B1=8'h01, RCI1=0 -> DONE1 pulses; Q_OUT=8'h00, RCO_OUT=1.
REQ-024 Contention after reset: REQ0 and REQ1 held high together -> served 0, 1, 0, 1 alternately; each DONE is 4 cycles after the previous one.
REQ-025 Reset mid-operation: RESET asserted in the WAIT cycle -> next cycle IDLE with all outputs 0 and no DONE; a re-issued REQ0 completes normally.
REQ-026 Operand change: A0 changed to 8'hAA during WAIT -> result still computed from the latched operands.
REQ-027 Latency sweep: ADD_LAT=4 -> DONE at cycle 6 after the sample edge; ENB high for exactly 1 cycle per transaction.
